// File: rtl/calc_cmd_feeder.sv
// Command feeder for the calculator: buffers host commands {a, op, b} in a FIFO,
// sends each one as a three-beat byte frame and returns the calculator result as a pulse.
module calc_cmd_feeder #(
    parameter int DEPTH   = 4,
    parameter int GAP     = 0,
    parameter int RES_LAT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_a,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_b,
    output logic       calc_valid,
    output logic [7:0] calc_data,
    input  logic [7:0] calc_out,
    output logic       res_valid,
    output logic [7:0] res_data,
    output logic       busy
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0]    CNT_ONE  = 1;
    localparam logic [AW-1:0]  PTR_ONE  = 1;
    localparam logic [2:0]     GAP_LOAD = (GAP > 0) ? 3'(GAP - 1) : 3'd0;

    typedef enum logic [2:0] {IDLE, SEND_A, SEND_OP, SEND_B, GAP_WAIT} state_t;

    logic [17:0]        mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    state_t             state_q, state_d;
    logic [17:0]        frame_q, frame_d;
    logic [2:0]         gap_q, gap_d;
    logic [RES_LAT-1:0] tag_q, tag_d;
    logic               res_valid_q, res_valid_d;
    logic [7:0]         res_data_q, res_data_d;
    logic               push, pop, fifo_empty;

    assign cmd_ready  = (count_q != FULL_CNT);
    assign push       = cmd_valid && cmd_ready;
    assign fifo_empty = (count_q == '0);

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        gap_d   = gap_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SEND_A;
                end
            end
            SEND_A:  state_d = SEND_OP;
            SEND_OP: state_d = SEND_B;
            SEND_B: begin
                if (GAP > 0) begin
                    gap_d   = GAP_LOAD;
                    state_d = GAP_WAIT;
                end else if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SEND_A;
                end else begin
                    state_d = IDLE;
                end
            end
            GAP_WAIT: begin
                if (gap_q == 3'd0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = SEND_A;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q - 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (pop) frame_d = mem_q[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) count_d = count_q + CNT_ONE;
        if (pop && !push) count_d = count_q - CNT_ONE;
    end

    // Tag marks the byte-B beat; when it leaves the pipe, calc_out is settled.
    always_comb begin
        tag_d[0] = (state_q == SEND_B);
        for (int i = 1; i < RES_LAT; i++) tag_d[i] = tag_q[i-1];
        res_valid_d = tag_q[RES_LAT-1];
        res_data_d  = tag_q[RES_LAT-1] ? calc_out : res_data_q;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {cmd_a, cmd_op, cmd_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            gap_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tag_q       <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            gap_q       <= gap_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tag_q       <= tag_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    always_comb begin
        calc_valid = 1'b0;
        calc_data  = 8'd0;
        case (state_q)
            SEND_A:  begin calc_valid = 1'b1; calc_data = frame_q[17:10];          end
            SEND_OP: begin calc_valid = 1'b1; calc_data = {6'b0, frame_q[9:8]};    end
            SEND_B:  begin calc_valid = 1'b1; calc_data = frame_q[7:0];            end
            default: begin calc_valid = 1'b0; calc_data = 8'd0;                    end
        endcase
    end

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = (count_q != '0) || (state_q != IDLE) || (|tag_q);

endmodule

// File: tb/tb_calc_cmd_feeder.sv
// Bench for calc_cmd_feeder: two instances (GAP=0/RES_LAT=1 and GAP=2/RES_LAT=3),
// each driven by a small calculator model, checked against a command/result scoreboard.
module tb_calc_cmd_feeder;
    localparam int DEPTH = 4;
    localparam int LAT0  = 1;
    localparam int LAT1  = 3;
    localparam int GAP1  = 2;

    typedef struct packed {
        logic [7:0] a;
        logic [1:0] op;
        logic [7:0] b;
    } cmd_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] cmd_valid = 2'b00;
    logic [1:0] cmd_ready, calc_valid, res_valid, busy;
    logic [7:0] cmd_a = 8'd0, cmd_b = 8'd0;
    logic [1:0] cmd_op = 2'd0;
    logic [7:0] calc_data0, calc_data1, calc_out0, calc_out1, res_data0, res_data1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    cmd_t pend_q[$];
    cmd_t acc0[$], acc1[$];
    int   acyc0[$], acyc1[$];
    int   bcyc0[$], bcyc1[$], rcyc0[$], rcyc1[$];
    logic [7:0] bdat0[$], bdat1[$], rdat0[$], rdat1[$];
    int   idle_bad0 = 0, idle_bad1 = 0;
    bit   saw_full = 1'b0;

    calc_cmd_feeder #(.DEPTH(DEPTH), .GAP(0), .RES_LAT(LAT0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_a(cmd_a), .cmd_op(cmd_op), .cmd_b(cmd_b),
        .calc_valid(calc_valid[0]), .calc_data(calc_data0), .calc_out(calc_out0),
        .res_valid(res_valid[0]), .res_data(res_data0), .busy(busy[0])
    );

    calc_cmd_feeder #(.DEPTH(DEPTH), .GAP(GAP1), .RES_LAT(LAT1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_a(cmd_a), .cmd_op(cmd_op), .cmd_b(cmd_b),
        .calc_valid(calc_valid[1]), .calc_data(calc_data1), .calc_out(calc_out1),
        .res_valid(res_valid[1]), .res_data(res_data1), .busy(busy[1])
    );

    function automatic logic [7:0] calc_ref(input cmd_t c);
        logic [15:0] r;
        case (c.op)
            2'd0:    r = 16'(c.a) + 16'(c.b);
            2'd1:    r = 16'(c.a) - 16'(c.b);
            2'd2:    r = 16'(c.a) * 16'(c.b);
            default: r = 16'(c.a) * 16'(c.a);
        endcase
        return r[7:0];
    endfunction

    function automatic cmd_t mk(input int a, input int op, input int b);
        cmd_t c;
        c.a = 8'(a); c.op = 2'(op); c.b = 8'(b);
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        return mk($urandom_range(255), $urandom_range(3), $urandom_range(255));
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Calculator models: collect three beats, result lags the B beat by LATx cycles.
    int ci0 = 0, ci1 = 0;
    logic [7:0] ma0, ma1;
    logic [1:0] mo0, mo1;
    logic [7:0] st0 [3];
    logic [7:0] st1 [3];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ci0 <= 0; ma0 <= 8'd0; mo0 <= 2'd0;
            for (int i = 0; i < 3; i++) st0[i] <= 8'd0;
        end else begin
            if (calc_valid[0]) begin
                if (ci0 == 0)      ma0 <= calc_data0;
                else if (ci0 == 1) mo0 <= calc_data0[1:0];
                else               st0[0] <= calc_ref({ma0, mo0, calc_data0});
                ci0 <= (ci0 == 2) ? 0 : ci0 + 1;
            end
            for (int i = 1; i < 3; i++) st0[i] <= st0[i-1];
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ci1 <= 0; ma1 <= 8'd0; mo1 <= 2'd0;
            for (int j = 0; j < 3; j++) st1[j] <= 8'd0;
        end else begin
            if (calc_valid[1]) begin
                if (ci1 == 0)      ma1 <= calc_data1;
                else if (ci1 == 1) mo1 <= calc_data1[1:0];
                else               st1[0] <= calc_ref({ma1, mo1, calc_data1});
                ci1 <= (ci1 == 2) ? 0 : ci1 + 1;
            end
            for (int j = 1; j < 3; j++) st1[j] <= st1[j-1];
        end
    end

    assign calc_out0 = st0[LAT0-1];
    assign calc_out1 = st1[LAT1-1];

    always @(negedge clk) begin
        if (calc_valid[0]) begin bcyc0.push_back(cyc); bdat0.push_back(calc_data0); end
        else if (calc_data0 != 8'd0) idle_bad0++;
        if (res_valid[0]) begin rcyc0.push_back(cyc); rdat0.push_back(res_data0); end
        if (calc_valid[1]) begin bcyc1.push_back(cyc); bdat1.push_back(calc_data1); end
        else if (calc_data1 != 8'd0) idle_bad1++;
        if (res_valid[1]) begin rcyc1.push_back(cyc); rdat1.push_back(res_data1); end
    end

    function automatic int pops(input int d);
        return ((d == 0 ? bcyc0.size() : bcyc1.size()) + 2) / 3;
    endfunction

    task automatic clear_obs();
        acc0.delete(); acc1.delete(); acyc0.delete(); acyc1.delete();
        bcyc0.delete(); bcyc1.delete(); rcyc0.delete(); rcyc1.delete();
        bdat0.delete(); bdat1.delete(); rdat0.delete(); rdat1.delete();
        idle_bad0 = 0; idle_bad1 = 0; saw_full = 1'b0;
    endtask

    // Offers pend_q to dut d; occupancy = accepted - frames started decides cmd_ready.
    task automatic push_list(input int d, input int pct);
        int guard = 0;
        int occ;
        bit v;
        logic rdy, exp_rdy;
        while (pend_q.size() > 0 && guard < 400) begin
            @(negedge clk); #1;
            v = ($urandom_range(99) < pct);
            cmd_a = pend_q[0].a; cmd_op = pend_q[0].op; cmd_b = pend_q[0].b;
            cmd_valid[d] = v;
            occ = (d == 0 ? acc0.size() : acc1.size()) - pops(d);
            exp_rdy = (occ < DEPTH);
            rdy = cmd_ready[d];
            checks++;
            if (rdy !== exp_rdy) begin
                failures++;
                $display("FAIL cmd_ready dut%0d cyc=%0d got=%b exp=%b", d, cyc, rdy, exp_rdy);
            end
            if (!rdy) saw_full = 1'b1;
            if (v && rdy) begin
                if (d == 0) begin acc0.push_back(pend_q[0]); acyc0.push_back(cyc + 1); end
                else        begin acc1.push_back(pend_q[0]); acyc1.push_back(cyc + 1); end
                void'(pend_q.pop_front());
            end
            @(posedge clk);
            guard++;
        end
        @(negedge clk); #1;
        cmd_valid = 2'b00;
        if (pend_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL push_timeout dut%0d left=%0d exp=0", d, pend_q.size());
            pend_q.delete();
        end
    endtask

    task automatic wait_idle(input int d);
        int g = 0;
        while (busy[d] && g < 300) begin
            @(negedge clk); #1;
            g++;
        end
        if (busy[d]) begin
            checks++; failures++;
            $display("FAIL idle_timeout dut%0d busy=%b exp=0", d, busy[d]);
        end
        repeat (3) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] cd, rd;
        cmd_valid = 2'b00;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int pass = 0; pass < 2; pass++) begin
            for (int d = 0; d < 2; d++) begin
                cd = (d == 0) ? calc_data0 : calc_data1;
                rd = (d == 0) ? res_data0 : res_data1;
                checks++;
                if (cmd_ready[d] !== 1'b1 || calc_valid[d] !== 1'b0 || res_valid[d] !== 1'b0 || busy[d] !== 1'b0) begin
                    failures++;
                    $display("FAIL reset_ctrl dut%0d pass%0d got rdy=%b cv=%b rv=%b busy=%b exp 1 0 0 0",
                             d, pass, cmd_ready[d], calc_valid[d], res_valid[d], busy[d]);
                end
                checks++;
                if (cd !== 8'd0 || rd !== 8'd0) begin
                    failures++;
                    $display("FAIL reset_data dut%0d pass%0d got calc_data=%0d res_data=%0d exp 0 0", d, pass, cd, rd);
                end
            end
            if (pass == 0) begin
                #1 rst_n = 1'b1;
                repeat (2) @(negedge clk);
            end
        end
    endtask

    task automatic test_single_add();
        logic [7:0] exp_b [3];
        int e;
        exp_b[0] = 8'd5; exp_b[1] = 8'd0; exp_b[2] = 8'd4;
        clear_obs();
        pend_q.push_back(mk(5, 0, 4));
        push_list(0, 100);
        wait_idle(0);
        e = acyc0[0];
        checks++;
        if (bcyc0.size() != 3) begin failures++; $display("FAIL single_beats got=%0d exp=3", bcyc0.size()); end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bdat0[i] !== exp_b[i] || bcyc0[i] != e + 1 + i) begin
                failures++;
                $display("FAIL single_beat%0d got data=%0d cyc=%0d exp data=%0d cyc=%0d", i, bdat0[i], bcyc0[i], exp_b[i], e + 1 + i);
            end
        end
        checks++;
        if (rdat0.size() != 1 || rdat0[0] !== 8'd9 || rcyc0[0] != e + 3 + LAT0 + 1) begin
            failures++;
            $display("FAIL single_result got n=%0d val=%0d cyc=%0d exp n=1 val=9 cyc=%0d", rdat0.size(), rdat0[0], rcyc0[0], e + 3 + LAT0 + 1);
        end
        checks++;
        if (busy[0] !== 1'b0 || idle_bad0 != 0) begin
            failures++;
            $display("FAIL single_after got busy=%b idle_nonzero=%0d exp 0 0", busy[0], idle_bad0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_r [4];
        exp_r[0] = 8'd7; exp_r[1] = 8'd12; exp_r[2] = 8'd4; exp_r[3] = 8'd44;
        clear_obs();
        pend_q.push_back(mk(10, 1, 3));
        pend_q.push_back(mk(4, 2, 3));
        pend_q.push_back(mk(2, 3, 9));
        pend_q.push_back(mk(200, 0, 100));
        push_list(0, 100);
        wait_idle(0);
        checks++;
        if (bcyc0.size() != 12 || acyc0[3] != acyc0[0] + 3) begin
            failures++;
            $display("FAIL b2b_beats got=%0d accept_span=%0d exp 12 3", bcyc0.size(), acyc0[3] - acyc0[0]);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (bcyc0[i] != bcyc0[0] + i) begin
                failures++;
                $display("FAIL b2b_contig beat%0d got cyc=%0d exp=%0d", i, bcyc0[i], bcyc0[0] + i);
            end
        end
        checks++;
        if (rdat0.size() != 4) begin failures++; $display("FAIL b2b_nres got=%0d exp=4", rdat0.size()); end
        for (int j = 0; j < 4; j++) begin
            checks++;
            if (rdat0[j] !== exp_r[j] || rcyc0[j] != rcyc0[0] + 3 * j) begin
                failures++;
                $display("FAIL b2b_res%0d got val=%0d cyc=%0d exp val=%0d cyc=%0d", j, rdat0[j], rcyc0[j], exp_r[j], rcyc0[0] + 3 * j);
            end
        end
    endtask

    task automatic test_full_fifo();
        cmd_t c;
        clear_obs();
        for (int i = 0; i < 8; i++) pend_q.push_back(rnd_cmd());
        push_list(0, 100);
        wait_idle(0);
        checks++;
        if (!saw_full) begin failures++; $display("FAIL full_seen got=0 exp=1"); end
        checks++;
        if (acc0.size() != 8 || bdat0.size() != 24 || rdat0.size() != 8) begin
            failures++;
            $display("FAIL full_counts got acc=%0d beats=%0d res=%0d exp 8 24 8", acc0.size(), bdat0.size(), rdat0.size());
        end
        for (int j = 0; j < 8; j++) begin
            c = acc0[j];
            checks++;
            if (bdat0[3*j] !== c.a || bdat0[3*j+1] !== {6'b0, c.op} || bdat0[3*j+2] !== c.b || rdat0[j] !== calc_ref(c)) begin
                failures++;
                $display("FAIL full_frame%0d got %0d,%0d,%0d res=%0d exp %0d,%0d,%0d res=%0d", j,
                         bdat0[3*j], bdat0[3*j+1], bdat0[3*j+2], rdat0[j], c.a, c.op, c.b, calc_ref(c));
            end
        end
    endtask

    task automatic test_gap();
        cmd_t c;
        clear_obs();
        pend_q.push_back(rnd_cmd());
        pend_q.push_back(rnd_cmd());
        push_list(1, 100);
        wait_idle(1);
        checks++;
        if (bcyc1.size() != 6) begin failures++; $display("FAIL gap_beats got=%0d exp=6", bcyc1.size()); end
        checks++;
        if (bcyc1[1] != bcyc1[0] + 1 || bcyc1[2] != bcyc1[0] + 2 || bcyc1[4] != bcyc1[3] + 1 || bcyc1[5] != bcyc1[3] + 2) begin
            failures++;
            $display("FAIL gap_frame_contig got cycles %0d %0d %0d / %0d %0d %0d", bcyc1[0], bcyc1[1], bcyc1[2], bcyc1[3], bcyc1[4], bcyc1[5]);
        end
        checks++;
        if (bcyc1[3] - bcyc1[2] - 1 != GAP1) begin
            failures++;
            $display("FAIL gap_idle got=%0d exp=%0d", bcyc1[3] - bcyc1[2] - 1, GAP1);
        end
        for (int j = 0; j < 2; j++) begin
            c = acc1[j];
            checks++;
            if (bdat1[3*j] !== c.a || bdat1[3*j+2] !== c.b || rdat1[j] !== calc_ref(c) || rcyc1[j] != bcyc1[3*j+2] + LAT1 + 1) begin
                failures++;
                $display("FAIL gap_frame%0d got a=%0d b=%0d res=%0d rcyc=%0d exp a=%0d b=%0d res=%0d rcyc=%0d", j,
                         bdat1[3*j], bdat1[3*j+2], rdat1[j], rcyc1[j], c.a, c.b, calc_ref(c), bcyc1[3*j+2] + LAT1 + 1);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int g = 0;
        clear_obs();
        pend_q.push_back(mk(8, 2, 7));
        push_list(0, 100);
        while (bcyc0.size() < 2 && g < 20) begin
            @(negedge clk); #1;
            g++;
        end
        checks++;
        if (bcyc0.size() != 2) begin failures++; $display("FAIL rstmid_reach_op got beats=%0d exp=2", bcyc0.size()); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (calc_valid[0] !== 1'b0 || calc_data0 !== 8'd0 || busy[0] !== 1'b0 || cmd_ready[0] !== 1'b1 || res_valid[0] !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async got cv=%b cd=%0d busy=%b rdy=%b rv=%b exp 0 0 0 1 0",
                     calc_valid[0], calc_data0, busy[0], cmd_ready[0], res_valid[0]);
        end
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        checks++;
        if (rdat0.size() != 0 || cmd_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_discard got res=%0d rdy=%b busy=%b exp 0 1 0", rdat0.size(), cmd_ready[0], busy[0]);
        end
        clear_obs();
        pend_q.push_back(mk(3, 2, 3));
        push_list(0, 100);
        wait_idle(0);
        checks++;
        if (rdat0.size() != 1 || rdat0[0] !== 8'd9) begin
            failures++;
            $display("FAIL rstmid_after got n=%0d val=%0d exp n=1 val=9", rdat0.size(), rdat0[0]);
        end
    endtask

    task automatic test_res_lat();
        clear_obs();
        pend_q.push_back(mk(6, 1, 2));
        push_list(1, 100);
        wait_idle(1);
        checks++;
        if (rdat1.size() != 1 || rdat1[0] !== 8'd4 || rcyc1[0] != bcyc1[2] + LAT1 + 1) begin
            failures++;
            $display("FAIL reslat got n=%0d val=%0d cyc=%0d exp n=1 val=4 cyc=%0d", rdat1.size(), rdat1[0], rcyc1[0], bcyc1[2] + LAT1 + 1);
        end
    endtask

    task automatic test_random();
        cmd_t c;
        clear_obs();
        for (int i = 0; i < 12; i++) pend_q.push_back(rnd_cmd());
        push_list(1, 60);
        wait_idle(1);
        checks++;
        if (bdat1.size() != 36 || rdat1.size() != 12 || idle_bad1 != 0) begin
            failures++;
            $display("FAIL rand_counts got beats=%0d res=%0d idle_nonzero=%0d exp 36 12 0", bdat1.size(), rdat1.size(), idle_bad1);
        end
        for (int j = 0; j < 12; j++) begin
            c = acc1[j];
            checks++;
            if (bdat1[3*j] !== c.a || bdat1[3*j+1] !== {6'b0, c.op} || bdat1[3*j+2] !== c.b ||
                rdat1[j] !== calc_ref(c) || rcyc1[j] != bcyc1[3*j+2] + LAT1 + 1) begin
                failures++;
                $display("FAIL rand_frame%0d got %0d,%0d,%0d res=%0d exp %0d,%0d,%0d res=%0d", j,
                         bdat1[3*j], bdat1[3*j+1], bdat1[3*j+2], rdat1[j], c.a, c.op, c.b, calc_ref(c));
            end
            if (j > 0) begin
                checks++;
                if (bcyc1[3*j] - bcyc1[3*j-1] - 1 < GAP1) begin
                    failures++;
                    $display("FAIL rand_spacing frame%0d got idle=%0d exp>=%0d", j, bcyc1[3*j] - bcyc1[3*j-1] - 1, GAP1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_add();
        test_back_to_back();
        test_full_fifo();
        test_gap();
        test_reset_mid_frame();
        test_res_lat();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/calc_cmd_feeder.md
# calc_cmd_feeder

Upstream stage for the calculator block: accepts complete calculator commands (operand A, opcode, operand B) from a host over a valid/ready handshake and buffers them in a small FIFO. It serializes each command into the calculator's three-beat byte protocol on `calc_valid`/`calc_data`. It then samples the calculator's registered `out` at the correct cycle and returns it to the host as a one-cycle result pulse.

## Interface
- `DEPTH`, 4: command FIFO entries. Power of two, minimum 2.
- `GAP`, 0: idle cycles inserted on the calculator bus between frames. Range 0..7.
- `RES_LAT`, 1: cycles from the byte-B beat to a stable `calc_out`. Range 1..3.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `cmd_valid` in 1: host command offered.
- `cmd_ready` out 1: feeder can accept a command.
- `cmd_a` in 8: operand A.
- `cmd_op` in 2: opcode. 0 add, 1 sub, 2 mul, 3 square (A*A).
- `cmd_b` in 8: operand B, ignored by the calculator for square.
- `calc_valid` out 1: byte valid to the calculator.
- `calc_data` out 8: byte to the calculator.
- `calc_out` in 8: calculator result.
- `res_valid` out 1: one-cycle result pulse.
- `res_data` out 8: result value, meaningful only while `res_valid`=1.
- `busy` out 1: FIFO non-empty, frame in flight, or result pending.

## Operation
- **Command transfer:** occurs at a rising edge with `cmd_valid`=1 and `cmd_ready`=1. {a, op, b} is pushed into the FIFO.
- **`cmd_ready`:** equals !full, from the registered count. It stays 0 when full, even if a pop happens in the same cycle.
- **FIFO:** circular buffer. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits. Push and pop in the same cycle leave the count unchanged. The FIFO never overflows or underflows.
- **FSM states:** IDLE, SEND_A, SEND_OP, SEND_B, GAP_WAIT.
  - IDLE: if FIFO non-empty, pop the head into the frame register and go to SEND_A.
  - SEND_A goes to SEND_OP, and SEND_OP goes to SEND_B, unconditionally.
  - SEND_B with GAP>0: load the gap counter with GAP-1 and go to GAP_WAIT.
  - SEND_B with GAP=0: if FIFO non-empty, pop and go to SEND_A. Otherwise go to IDLE.
  - GAP_WAIT: decrement the gap counter. At 0, pop and go to SEND_A if FIFO non-empty, else go to IDLE.
- **Calculator bus outputs:** `calc_valid`=1 only in the SEND_* states.
  - `calc_data` is A in SEND_A, {6'b0, op} in SEND_OP, and B in SEND_B.
  - `calc_data`=0 when `calc_valid`=0.
  - Both are decoded only from the state register and frame register. There is no combinational path from inputs.
- **Result capture:** a RES_LAT-deep shift register of tag bits. A 1 enters in the SEND_B cycle and a 0 in every other cycle.
  - When the tag exits the shift register, `calc_out` is registered into `res_data` and `res_valid` is set for exactly one cycle.
  - Multiple frames can be in flight.
- **Arithmetic:** none in this block. Results are passed through at 8 bits. Wrap-around is the calculator's concern.
- **`busy`:** (count!=0) | (state!=IDLE) | (any tag bit set).

## Timing
- **Reset values:** `cmd_ready`=1, `calc_valid`=0, `calc_data`=0, `res_valid`=0, `res_data`=0, `busy`=0. The FIFO is empty, the FSM is in IDLE, and all tags are cleared.
- **Reset mid-operation:** all outputs go to their reset values immediately and asynchronously. Queued and in-flight frames are discarded. No `res_valid` is produced for them.
- **Accept-to-bus latency:** a command accepted at edge E into an empty, idle feeder has A on the bus in the cycle after edge E+1. That is 2 cycles, followed by op and B in the next two consecutive cycles.
- **Throughput:** with GAP=0 and a non-empty FIFO, frames are contiguous: 3 valid beats per command and no bubbles. The minimum spacing between frames is GAP idle cycles.
- **Result latency:** if SEND_B is cycle k, `calc_out` is sampled at the end of cycle k+RES_LAT. `res_valid`=1 in cycle k+RES_LAT+1.
- **No result backpressure:** the host must take `res_data` during the `res_valid` cycle.

## Test plan
- **Single add:** push (5,0,4) into an idle feeder. Expect bus beats 5, 0, 4 in consecutive cycles starting 2 cycles after accept, then `res_valid` pulse with `res_data`=9, then `busy` falls.
- **Back-to-back, GAP=0:** push (10,1,3), (4,2,3), (2,3,9), (200,0,100) on consecutive cycles. Expect 12 contiguous `calc_valid` cycles. Expect 4 `res_valid` pulses spaced 3 cycles apart with values 7, 12, 4, 44.
- **Full FIFO, DEPTH=4:** push 8 commands with `cmd_valid` held high. Expect `cmd_ready` low whenever count=4. Every accepted command appears exactly once, in order. The FIFO pointers wrap with no loss or duplication.
- **GAP=2:** push two commands. Expect exactly 2 cycles of `calc_valid`=0 between the B beat of frame 1 and the A beat of frame 2.
- **Reset mid-frame:** assert `rst_n`=0 during SEND_OP. Expect `calc_valid`=0 at once and no `res_valid` for that frame. After release, `cmd_ready`=1, and a new (3,2,3) produces `res_data`=9.
- **RES_LAT=3:** with a calculator model whose output lags by 3 cycles, push (6,1,2). Expect `res_valid` in cycle k+4 with `res_data`=4.
